lcv_mul_acc_seq: RTL and testbench

//  Streaming dot-product sequencer that sits directly upstream of, and wraps, the signed
//  16x16 multiply-accumulate datapath. Accepts (a,b) operand pairs on a valid/ready stream,

---
 rtl/lcv_mul_acc_seq_pkg.sv | 21 ++
 rtl/lcv_mul_acc_core.sv | 40 ++++
 rtl/lcv_mul_acc_seq.sv | 88 ++++++++
 tb/tb_lcv_mul_acc_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lcv_mul_acc_seq_pkg.sv
// Shared constants, FSM state encoding and overflow helper for the
// streaming multiply-accumulate sequencer.
package lcv_mul_acc_seq_pkg;

  localparam int unsigned LCV_MAC_OP_W   = 16;
  localparam int unsigned LCV_MAC_ACC_W  = 33;
  localparam int unsigned LCV_MAC_FULL_W = 36;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } lcv_mac_state_e;

  // The full sum has left the signed 33-bit range when its top bits
  // are not a pure sign extension of bit 32.
  function automatic logic full_ovf(input logic [LCV_MAC_FULL_W-1:0] full);
    return full[35:33] != {3{full[32]}};
  endfunction

endpackage

// File: rtl/lcv_mul_acc_core.sv
// Registered signed 16x16 multiply plus 33-bit addend, with a sticky
// range-overflow flag that can be cleared by the first beat of a vector.
module lcv_mul_acc_core
  import lcv_mul_acc_seq_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            en_i,
  input  logic                            clr_i,
  input  logic signed [LCV_MAC_OP_W-1:0]  a_i,
  input  logic signed [LCV_MAC_OP_W-1:0]  b_i,
  input  logic        [LCV_MAC_ACC_W-1:0] c_i,
  output logic        [LCV_MAC_ACC_W-1:0] acc_o,
  output logic                            ovf_o
);

  (* use_dsp48 = "yes" *) logic signed [31:0] prod;
  logic [LCV_MAC_FULL_W-1:0] full;
  logic [LCV_MAC_ACC_W-1:0]  acc_q;
  logic                      ovf_q;

  always_comb begin
    prod = a_i * b_i;
    full = {{4{prod[31]}}, prod} + {{3{c_i[32]}}, c_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      acc_q <= full[LCV_MAC_ACC_W-1:0];
      ovf_q <= (clr_i ? 1'b0 : ovf_q) | full_ovf(full);
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/lcv_mul_acc_seq.sv
// Streaming dot-product sequencer: accepts (a,b) pairs, accumulates
// bias + sum(a*b) per vector and presents one held result per vector.
module lcv_mul_acc_seq
  import lcv_mul_acc_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ACC_W = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  input  logic [ACC_W-1:0] bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  lcv_mac_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             first;
  logic             hold;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] addend;
  logic             ovf;

  assign hold = (state_q == ST_HOLD);

  // rst gates in_ready so nothing is offered as accepted while in reset.
  always_comb begin
    in_ready = rst && (hold ? out_ready : 1'b1);
    accept   = in_valid && in_ready;
    first    = accept && (state_q != ST_ACC);
    addend   = first ? bias : acc;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = in_last ? ST_HOLD : ST_ACC;
      ST_ACC:  if (accept && in_last) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = accept ? (in_last ? ST_HOLD : ST_ACC) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (first) begin
      cnt_d = CNT_W'(1);
    end else if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  lcv_mul_acc_core u_core (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (accept),
    .clr_i  (first),
    .a_i    (in_a),
    .b_i    (in_b),
    .c_i    (addend),
    .acc_o  (acc),
    .ovf_o  (ovf)
  );

  always_comb begin
    out_valid = hold;
    out_sum   = hold ? acc : '0;
    out_cnt   = hold ? cnt_q : '0;
    out_ovf   = hold && ovf;
  end

endmodule

// File: tb/tb_lcv_mul_acc_seq.sv
// Directed bench for the dot-product sequencer: reset, short vectors,
// wrap/overflow, output backpressure and a long gapped vector.
module tb_lcv_mul_acc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic [32:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_sum;
  logic [7:0]  out_cnt;
  logic        out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  lcv_mul_acc_seq #(.CNT_W(8), .ACC_W(33)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] s33(input longint v);
    return v[32:0];
  endfunction

  task automatic send_beat(input int a, input int b, input logic last, input longint bv);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a[15:0];
    in_b     = b[15:0];
    in_last  = last;
    bias     = s33(bv);
    #1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_last  = 1'($urandom);
    bias     = 33'($urandom);
  endtask

  task automatic expect_result(input string tag, input logic [32:0] es, input logic [7:0] ec,
                               input logic eo);
    int t;
    out_ready = 1'b1;
    @(negedge clk);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".sum"}, 64'(out_sum), 64'(es));
    check({tag, ".cnt"}, 64'(out_cnt), 64'(ec));
    check({tag, ".ovf"}, 64'(out_ovf), 64'(eo));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    longint accm;
    longint full;
    logic   ovfm;
    int     a, b;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_last = 1'b0; bias = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.sum", 64'(out_sum), 64'd0);
    check("rst.cnt", 64'(out_cnt), 64'd0);
    check("rst.ovf", 64'(out_ovf), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;

    // Reset mid-vector, then a fresh vector must start from bias
    send_beat(1, 1, 1'b0, 100);
    send_beat(2, 2, 1'b0, 100);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.valid", 64'(out_valid), 64'd0);
    check("midrst.sum", 64'(out_sum), 64'd0);
    check("midrst.cnt", 64'(out_cnt), 64'd0);
    check("midrst.in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send_beat(2, 3, 1'b0, 7);
    send_beat(1, 1, 1'b1, 7);
    expect_result("rst_recover", s33(14), 8'd2, 1'b0);

    // 5 + 12 - 14 - 100 = -97, result valid right after the last beat
    send_beat(3, 4, 1'b0, 5);
    send_beat(-2, 7, 1'b0, 5);
    check("vec3.no_early", 64'(out_valid), 64'd0);
    send_beat(100, -1, 1'b1, 5);
    check("vec3.latency", 64'(out_valid), 64'd1);
    expect_result("vec3", s33(-97), 8'd3, 1'b0);

    // Single beat, most-negative squared
    send_beat(-32768, -32768, 1'b1, 0);
    expect_result("single", s33(1073741824), 8'd1, 1'b0);

    // Max positive bias + 1 wraps to most negative and flags overflow
    send_beat(1, 1, 1'b1, 64'h0_FFFF_FFFF);
    expect_result("ovf", 33'h1_0000_0000, 8'd1, 1'b1);
    send_beat(1, 1, 1'b1, 0);
    expect_result("ovf_clear", s33(1), 8'd1, 1'b0);

    // Backpressure, then next vector's first beat on the releasing cycle
    send_beat(2, 2, 1'b1, 10);
    in_valid = 1'b1; in_a = 16'd5; in_b = 16'd6; in_last = 1'b1; bias = s33(-1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp.valid", 64'(out_valid), 64'd1);
      check("bp.sum", 64'(out_sum), 64'd14);
      check("bp.cnt", 64'(out_cnt), 64'd1);
      check("bp.in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    expect_result("bp_next", s33(29), 8'd1, 1'b0);

    // 300-beat vector with random input gaps; count saturates at 255
    accm = -123456789;
    ovfm = 1'b0;
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      full = longint'(a) * longint'(b) + accm;
      if (full > 64'sd4294967295 || full < -64'sd4294967296) ovfm = 1'b1;
      accm = longint'($signed(full[32:0]));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(a, b, i == 299, (i == 0) ? -123456789 : longint'($urandom));
    end
    expect_result("long", accm[32:0], 8'hFF, ovfm);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
